// File: rtl/uart_rx_poll_if.sv
// uart_rx_poll_if: CPU-side polled interface of the console UART receiver.
//   rd_stb    : CPU read acknowledge, one clock wide
//   rx_data   : last accepted byte
//   rx_ready  : byte available and not yet acknowledged
//   overrun   : a byte was lost because rx_ready was still set
//   frame_err : stop bit sampled low on the last accepted byte
//   rx_busy   : receiver is inside a frame
// Modports: master = CPU / bus decode side, slave = receiver.
interface uart_rx_poll_if #(
   parameter int DATA_BITS = 8
);
   logic                 rd_stb;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_ready;
   logic                 overrun;
   logic                 frame_err;
   logic                 rx_busy;

   modport master (
      output rd_stb,
      input  rx_data, rx_ready, overrun, frame_err, rx_busy
   );

   modport slave (
      input  rd_stb,
      output rx_data, rx_ready, overrun, frame_err, rx_busy
   );
endinterface

// File: rtl/uart_rx_poll.sv
// uart_rx_poll: 16x-oversampled asynchronous serial receiver for the polled
// console UART. baud_tick (con_clk0) is the oversample enable.
//   clock_in  : system clock
//   reset_n   : asynchronous active-low reset
//   baud_tick : one-cycle oversample enable pulse
//   rxd       : asynchronous serial input, idles high
//   bus       : uart_rx_poll_if.slave (rd_stb in; rx_data, rx_ready,
//               overrun, frame_err, rx_busy out)
// Optional feature macro: UART_RX_MAJORITY_EN -- each bit decision becomes the
// 2-of-3 majority of rxs at tick_cnt 7, 8 and 9, decided at tick_cnt 9.
//
// state | meaning
// IDLE  | waiting for a falling edge on an armed (previously high) line
// START | counting into the start bit, validating it at mid-bit
// DATA  | sampling DATA_BITS data bits, LSB first
// STOP  | sampling the stop bit and completing the frame
module uart_rx_poll #(
   parameter int DATA_BITS   = 8,
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic            clock_in,
   input  logic            reset_n,
   input  logic            baud_tick,
   input  logic            rxd,
   uart_rx_poll_if.slave   bus
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

`ifdef UART_RX_MAJORITY_EN
   // Counter keeps the bit boundary at T_LAST; samples straddle the centre.
   localparam logic [TW-1:0] T_MAJ1    = TW'(OVERSAMPLE / 2);
   localparam logic [TW-1:0] START_DEC = TW'(OVERSAMPLE / 2 + 1);
   localparam logic [TW-1:0] START_END = T_LAST;
   localparam logic [TW-1:0] BIT_DEC   = TW'(OVERSAMPLE / 2 + 1);
`else
   // Start check at mid-bit re-zeroes the counter, so T_LAST lands mid-bit.
   localparam logic [TW-1:0] START_DEC = T_MID;
   localparam logic [TW-1:0] START_END = T_MID;
   localparam logic [TW-1:0] BIT_DEC   = T_LAST;
`endif

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t               state;
   logic [TW-1:0]        tick_cnt;
   logic [BW-1:0]        bit_cnt;
   logic                 armed;
   logic [DATA_BITS-1:0] shift;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                 rxs;
   logic                 bit_val;
   logic                 frame_done;

   logic [DATA_BITS-1:0] rx_data_q;
   logic                 rx_ready_q;
   logic                 overrun_q;
   logic                 frame_err_q;
   logic                 rx_busy_q;

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) sync_q <= '1;
      else          sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
   end

   assign rxs = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] maj_q;

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         maj_q <= '0;
      end else if (baud_tick && state != IDLE) begin
         if (tick_cnt == T_MID)  maj_q[0] <= rxs;
         if (tick_cnt == T_MAJ1) maj_q[1] <= rxs;
      end
   end

   assign bit_val = (maj_q[0] & maj_q[1]) | (maj_q[0] & rxs) | (maj_q[1] & rxs);
`else
   assign bit_val = rxs;
`endif

   assign frame_done = baud_tick && (state == STOP) && (tick_cnt == BIT_DEC);

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         tick_cnt    <= '0;
         bit_cnt     <= '0;
         armed       <= 1'b0;
         shift       <= '0;
         rx_data_q   <= '0;
         rx_ready_q  <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
         rx_busy_q   <= 1'b0;
      end else begin
         // A read on the completion edge makes room for the new byte.
         if (frame_done) begin
            if (!rx_ready_q || bus.rd_stb) begin
               rx_data_q   <= shift;
               rx_ready_q  <= 1'b1;
               frame_err_q <= ~bit_val;
            end else begin
               overrun_q <= 1'b1;
            end
         end else if (bus.rd_stb && rx_ready_q) begin
            rx_ready_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
         end

         if (baud_tick) begin
            case (state)
               IDLE: begin
                  // armed blocks a held-low line (break) from retriggering
                  if (rxs) begin
                     armed <= 1'b1;
                  end else if (armed) begin
                     state     <= START;
                     tick_cnt  <= '0;
                     armed     <= 1'b0;
                     rx_busy_q <= 1'b1;
                  end
               end
               START: begin
                  tick_cnt <= tick_cnt + 1'b1;
                  if (tick_cnt == START_DEC && bit_val) begin
                     state     <= IDLE;
                     rx_busy_q <= 1'b0;
                  end else if (tick_cnt == START_END) begin
                     state    <= DATA;
                     tick_cnt <= '0;
                     bit_cnt  <= '0;
                  end
               end
               DATA: begin
                  tick_cnt <= tick_cnt + 1'b1;
                  if (tick_cnt == BIT_DEC)
                     shift <= {bit_val, shift[DATA_BITS-1:1]};
                  if (tick_cnt == T_LAST) begin
                     bit_cnt <= bit_cnt + 1'b1;
                     if (bit_cnt == B_LAST) state <= STOP;
                  end
               end
               STOP: begin
                  tick_cnt <= tick_cnt + 1'b1;
                  if (tick_cnt == BIT_DEC) begin
                     state     <= IDLE;
                     rx_busy_q <= 1'b0;
                  end
               end
               default: begin
                  state     <= IDLE;
                  rx_busy_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.rx_data   = rx_data_q;
   assign bus.rx_ready  = rx_ready_q;
   assign bus.overrun   = overrun_q;
   assign bus.frame_err = frame_err_q;
   assign bus.rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_uart_rx_poll.sv
// tb_uart_rx_poll: directed plus randomized frames for uart_rx_poll, checked
// against a flag-level model of the receiver's CPU-visible behaviour.
module tb_uart_rx_poll;

   localparam int TICK_DIV = 4;
   localparam int OS       = 16;
`ifdef UART_RX_MAJORITY_EN
   localparam int DONE_T   = 11;
   localparam bit GLITCH   = 1'b1;
`else
   localparam int DONE_T   = 9;
   localparam bit GLITCH   = 1'b0;
`endif

   logic clock_in  = 1'b0;
   logic reset_n   = 1'b0;
   logic baud_tick = 1'b0;
   logic rxd       = 1'b1;
   int   tcnt      = 0;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] m_data;
   logic       m_ready, m_ovr, m_fe;

   uart_rx_poll_if #(.DATA_BITS(8)) bus ();

   uart_rx_poll #(.DATA_BITS(8), .OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
      .clock_in  (clock_in),
      .reset_n   (reset_n),
      .baud_tick (baud_tick),
      .rxd       (rxd),
      .bus       (bus)
   );

   always #5 clock_in = ~clock_in;

   always @(negedge clock_in) begin
      tcnt      = (tcnt == TICK_DIV - 1) ? 0 : tcnt + 1;
      baud_tick = (tcnt == 0);
   end

   initial begin
      #800000;
      $display("FAIL watchdog: observed no finish, expected finish before 800000 ns");
      $fatal(1, "watchdog expired");
   end

   function automatic void m_reset();
      m_data = 8'h00; m_ready = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
   endfunction

   function automatic void m_done(input logic [7:0] b, input logic stop, input logic rd);
      if (!m_ready || rd) begin
         m_data = b; m_ready = 1'b1; m_fe = ~stop;
      end else begin
         m_ovr = 1'b1;
      end
   endfunction

   function automatic void m_read();
      if (m_ready) begin
         m_ready = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic exp_busy);
      chk({tag, "_data"},  32'(bus.rx_data),   32'(m_data));
      chk({tag, "_ready"}, 32'(bus.rx_ready),  32'(m_ready));
      chk({tag, "_ovr"},   32'(bus.overrun),   32'(m_ovr));
      chk({tag, "_ferr"},  32'(bus.frame_err), 32'(m_fe));
      chk({tag, "_busy"},  32'(bus.rx_busy),   32'(exp_busy));
   endtask

   // Returns 1 ns after a posedge on which baud_tick was high.
   task automatic next_tick();
      do @(posedge clock_in); while (!baud_tick);
      #1;
   endtask

   task automatic drive_bit(input logic val, input logic glitch);
      for (int t = 0; t < OS; t++) begin
         next_tick();
         rxd = (glitch && t == 8) ? ~val : val;
      end
   endtask

   task automatic rd_pulse();
      @(posedge clock_in); #1 bus.rd_stb = 1'b1;
      @(posedge clock_in); #1 bus.rd_stb = 1'b0;
      m_read();
   endtask

   // Sends one frame; rd_at_done pulses rd_stb on the completion edge and
   // chk_lat checks rx_ready across that edge.
   task automatic send_frame(input logic [7:0] b, input logic stop, input logic glitch,
                             input logic rd_at_done, input logic chk_lat);
      drive_bit(1'b0, 1'b0);
      for (int k = 0; k < 8; k++) drive_bit(b[k], glitch);
      for (int t = 0; t < OS; t++) begin
         next_tick();
         rxd = (glitch && t == 8) ? ~stop : stop;
         if (t == DONE_T - 1 && (rd_at_done || chk_lat)) begin
            repeat (TICK_DIV - 1) @(posedge clock_in);
            #1;
            if (chk_lat) chk("lat_before", 32'(bus.rx_ready), 32'(1'b0));
            if (rd_at_done) bus.rd_stb = 1'b1;
            @(posedge clock_in);
            #1 bus.rd_stb = 1'b0;
            if (chk_lat) chk("lat_edge", 32'(bus.rx_ready), 32'(1'b1));
         end
      end
      m_done(b, stop, rd_at_done);
   endtask

   initial begin
      logic [7:0] rb;
      logic       rs;
      bus.rd_stb = 1'b0;
      m_reset();
      repeat (5) @(posedge clock_in);
      #1;
      check_all("reset", 1'b0);
      reset_n = 1'b1;
      repeat (32) next_tick();

      // 0x55, good stop, latency edge check, then read
      send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b1);
      check_all("f55", 1'b0);
      rd_pulse();
      check_all("f55_rd", 1'b0);

      // 4-tick low pulse: false start
      next_tick(); rxd = 1'b0;
      repeat (3) next_tick();
      chk("false_busy", 32'(bus.rx_busy), 32'(1'b1));
      next_tick(); rxd = 1'b1;
      repeat (20) next_tick();
      check_all("false_start", 1'b0);

      // 0xA3 with low stop, line then held low
      send_frame(8'hA3, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) drive_bit(1'b0, 1'b0);
      check_all("break_low", 1'b0);
      rxd = 1'b1;
      repeat (32) next_tick();
      check_all("break_high", 1'b0);
      rd_pulse();
      check_all("break_rd", 1'b0);

      // back-to-back without read: overrun
      send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
      check_all("overrun", 1'b0);
      rd_pulse();
      check_all("overrun_rd", 1'b0);

      // read on the exact completion edge of the second byte
      send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0, 1'b1, 1'b0);
      check_all("rd_same_edge", 1'b0);

      // reset in data bit 4 of 0xFF, then clean 0x3C
      drive_bit(1'b0, 1'b0);
      repeat (4) drive_bit(1'b1, 1'b0);
      repeat (8) next_tick();
      reset_n = 1'b0;
      #2;
      m_reset();
      check_all("mid_reset", 1'b0);
      rxd = 1'b1;
      repeat (3) @(posedge clock_in);
      #1 reset_n = 1'b1;
      repeat (32) next_tick();
      send_frame(8'h3C, 1'b1, GLITCH, 1'b0, 1'b0);
      check_all("f3c", 1'b0);

      // randomized frames with random reads and occasional bad stop bits
      for (int i = 0; i < 10; i++) begin
         rb = 8'($urandom_range(0, 255));
         rs = ($urandom_range(0, 3) != 0);
         send_frame(rb, rs, 1'b0, 1'b0, 1'b0);
         rxd = 1'b1;
         repeat (2) next_tick();
         check_all("rand", 1'b0);
         if ($urandom_range(0, 1) == 1) begin
            rd_pulse();
            check_all("rand_rd", 1'b0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
